// File: rtl/rms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rms_pkg
// Purpose  : Shared types and width helpers for the RMS datapath.
// Revision : 1.0 - initial release
// ============================================================================
package rms_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Accumulator width: N squares of 2*DATA_W bits cannot exceed this.
    function automatic int ACC_W(input int data_w, input int log2_n);
        return 2 * data_w + log2_n;
    endfunction

    function automatic int OUT_W(input int data_w);
        return 2 * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rms_square_reg.sv
`default_nettype none
// ============================================================================
// Module   : rms_square_reg
// Purpose  : Registered squarer with valid flag; handles signed/unsigned input.
// Revision : 1.0 - initial release
// ============================================================================
module rms_square_reg #(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  i_en,
    input  logic [DATA_W-1:0]     i_data,
    output logic [2*DATA_W-1:0]   o_sq,
    output logic                  o_sq_vld
);

    localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1);

    logic                  w_neg;
    logic [DATA_W-1:0]     w_mag;
    logic [2*DATA_W-1:0]   w_sq;
    logic [2*DATA_W-1:0]   r_sq;
    logic                  r_sq_vld;

    // |x| of a two's complement DATA_W value always fits in DATA_W unsigned bits.
    assign w_neg = (SIGNED != 0) && i_data[DATA_W-1];
    assign w_mag = w_neg ? (~i_data + C_ONE) : i_data;
    assign w_sq  = {{DATA_W{1'b0}}, w_mag} * {{DATA_W{1'b0}}, w_mag};

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_sq     <= '0;
            r_sq_vld <= 1'b0;
        end else begin
            r_sq_vld <= i_en;
            if (i_en) begin
                r_sq <= w_sq;
            end
        end
    end

    assign o_sq     = r_sq;
    assign o_sq_vld = r_sq_vld;

endmodule
`default_nettype wire

// File: rtl/mean_square_acc.sv
`default_nettype none
// ============================================================================
// Module   : mean_square_acc
// Purpose  : Squares and accumulates a 2^LOG2_N sample window, emits floor(mean square).
// Revision : 1.0 - initial release
// ============================================================================
module mean_square_acc
    import rms_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*DATA_W-1:0]   m_data
);

    localparam int C_ACC_W = ACC_W(DATA_W, LOG2_N);
    localparam int C_OUT_W = OUT_W(DATA_W);
    localparam int C_CNT_W = LOG2_N + 1;
    localparam logic [C_CNT_W-1:0] C_LAST    = C_CNT_W'((1 << LOG2_N) - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_ACC_W-1:0]   r_acc;
    logic                 r_m_valid;
    logic [C_OUT_W-1:0]   r_m_data;

    logic                 w_accept;
    logic [C_OUT_W-1:0]   w_sq;
    logic                 w_sq_vld;
    logic [C_ACC_W-1:0]   w_acc_sum;
    logic [C_OUT_W-1:0]   w_mean;

    assign s_ready  = (r_state == ACC);
    assign w_accept = s_valid && s_ready;

    rms_square_reg #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_square (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .i_en     (w_accept),
        .i_data   (s_data),
        .o_sq     (w_sq),
        .o_sq_vld (w_sq_vld)
    );

    // Accumulator including any square still in flight; mean is a plain bit slice.
    assign w_acc_sum = r_acc + (w_sq_vld ? {{LOG2_N{1'b0}}, w_sq} : {C_ACC_W{1'b0}});
    assign w_mean    = w_acc_sum[C_ACC_W-1:LOG2_N];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC: begin
                if (w_accept && (r_cnt == C_LAST)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the last square has been folded into the accumulator.
                if (!w_sq_vld) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    w_state_nxt = ACC;
                end
            end
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state   <= ACC;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == DONE) && m_ready) begin
                r_acc     <= '0;
                r_cnt     <= '0;
                r_m_valid <= 1'b0;
            end else begin
                r_acc <= w_acc_sum;
                if (w_accept) begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
                if ((r_state == DRAIN) && !w_sq_vld) begin
                    r_m_data  <= w_mean;
                    r_m_valid <= 1'b1;
                end
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_mean_square_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mean_square_acc
// Purpose  : Directed bench for mean_square_acc, unsigned and signed instances side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mean_square_acc;

    localparam int DATA_W = 8;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        m_ready;

    logic        s_ready_u, m_valid_u;
    logic [15:0] m_data_u;
    logic        s_ready_s, m_valid_s;
    logic [15:0] m_data_s;

    int n_assert = 0;
    int n_fail   = 0;

    mean_square_acc #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready_u), .s_data(s_data),
        .m_valid(m_valid_u), .m_ready(m_ready), .m_data(m_data_u)
    );

    mean_square_acc #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
        .m_valid(m_valid_s), .m_ready(m_ready), .m_data(m_data_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic longint sqf(input logic [7:0] d, input bit sgn);
        longint x;
        if (sgn) x = longint'($signed(d));
        else     x = longint'({56'd0, d});
        return x * x;
    endfunction

    // Window-level reference: collect N samples, result appears two edges after
    // the last one, input is refused until the result is taken.
    bit     model_on = 0;
    int     mcnt     = 0;
    bit     mbusy    = 0;
    int     mtimer   = 0;
    bit     mvld     = 0;
    longint msum [2] = '{0, 0};
    longint mdat [2] = '{0, 0};

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n || clear) begin
                if (!rst_n) model_on = 1;
                mcnt = 0; mbusy = 0; mtimer = 0; mvld = 0;
                msum[0] = 0; msum[1] = 0; mdat[0] = 0; mdat[1] = 0;
            end else if (mvld && m_ready) begin
                mvld = 0; mbusy = 0; mcnt = 0;
                msum[0] = 0; msum[1] = 0;
            end else if (s_valid && !mbusy) begin
                msum[0] += sqf(s_data, 1'b0);
                msum[1] += sqf(s_data, 1'b1);
                mcnt++;
                if (mcnt == N) begin
                    mbusy  = 1;
                    mtimer = 2;
                end
            end else if (mtimer > 0) begin
                mtimer--;
                if (mtimer == 0) begin
                    mvld    = 1;
                    mdat[0] = msum[0] / N;
                    mdat[1] = msum[1] / N;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_on) begin
                chk("u_s_ready", {31'd0, s_ready_u}, {31'd0, !mbusy});
                chk("u_m_valid", {31'd0, m_valid_u}, {31'd0, mvld});
                chk("u_m_data",  {16'd0, m_data_u},  32'(mdat[0]));
                chk("s_s_ready", {31'd0, s_ready_s}, {31'd0, !mbusy});
                chk("s_m_valid", {31'd0, m_valid_s}, {31'd0, mvld});
                chk("s_m_data",  {16'd0, m_data_s},  32'(mdat[1]));
            end
        end
    end

    task automatic push_one(input logic [7:0] d);
        int tries;
        s_valid = 1'b1;
        s_data  = d;
        tries   = 0;
        while (!s_ready_u && tries < 40) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 40) begin
            n_assert++;
            n_fail++;
            $display("FAIL push_timeout actual=%0d required=<40", tries);
        end
        @(negedge clk);
    endtask

    task automatic push_win(input logic [7:0] v0, v1, v2, v3, input int gap);
        logic [7:0] v [4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            push_one(v[i]);
            if (gap > 0 && i < 3) begin
                s_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [15:0] du, output logic [15:0] ds, output int lat);
        lat = 0;
        while (!m_valid_u && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) begin
            n_assert++;
            n_fail++;
            $display("FAIL result_timeout actual=%0d required=<40", lat);
        end
        du = m_data_u;
        ds = m_data_s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] du, ds, hold;
    int          lat;

    initial begin
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", {31'd0, m_valid_u}, 32'd0);
        chk("rst_m_data",  {16'd0, m_data_u},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready_u}, 32'd1);

        // Basic window and latency
        push_win(8'd1, 8'd2, 8'd3, 8'd4, 0);
        wait_result(du, ds, lat);
        chk("t1_mean", {16'd0, du}, 32'd7);
        chk("t1_latency", lat, 32'd2);
        @(negedge clk);
        chk("t1_valid_pulse", {31'd0, m_valid_u}, 32'd0);
        chk("t1_ready_back",  {31'd0, s_ready_u}, 32'd1);
        chk("t1_data_hold",   {16'd0, m_data_u},  32'd7);

        // Extremes and signed interpretation
        push_win(8'd255, 8'd255, 8'd255, 8'd255, 0);
        wait_result(du, ds, lat);
        chk("t2_max_unsigned", {16'd0, du}, 32'd65025);
        push_win(8'h80, 8'h80, 8'h80, 8'h80, 0);
        wait_result(du, ds, lat);
        chk("t2_min_signed", {16'd0, ds}, 32'd16384);
        push_win(8'hFD, 8'h03, 8'hFD, 8'h03, 0);
        wait_result(du, ds, lat);
        chk("t2_pm3_signed", {16'd0, ds}, 32'd9);

        // Backpressure with samples offered during the stall
        @(negedge clk);
        m_ready = 1'b0;
        push_win(8'd10, 8'd10, 8'd10, 8'd10, 0);
        wait_result(du, ds, lat);
        chk("t3_mean", {16'd0, du}, 32'd100);
        hold = du;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'd77;
            @(negedge clk);
            chk("t3_stall_valid", {31'd0, m_valid_u}, 32'd1);
            chk("t3_stall_data",  {16'd0, m_data_u},  {16'd0, hold});
            chk("t3_stall_ready", {31'd0, s_ready_u}, 32'd0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        push_win(8'd2, 8'd2, 8'd2, 8'd2, 0);
        wait_result(du, ds, lat);
        chk("t3_next_window", {16'd0, du}, 32'd4);

        // Gapped input
        push_win(8'd5, 8'd0, 8'd0, 8'd5, 1);
        wait_result(du, ds, lat);
        chk("t4_gapped", {16'd0, du}, 32'd12);

        // Reset mid-window
        push_one(8'd100);
        push_one(8'd100);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", {31'd0, m_valid_u}, 32'd0);
        chk("t5_rst_data",  {16'd0, m_data_u},  32'd0);
        rst_n = 1'b1;
        push_win(8'd2, 8'd2, 8'd2, 8'd2, 0);
        wait_result(du, ds, lat);
        chk("t5_after_rst", {16'd0, du}, 32'd4);

        // Clear mid-window, with a sample offered in the clear cycle
        push_one(8'd100);
        push_one(8'd100);
        clear   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'd50;
        @(negedge clk);
        clear   = 1'b0;
        s_valid = 1'b0;
        chk("t6_clr_data", {16'd0, m_data_u}, 32'd0);
        push_win(8'd3, 8'd3, 8'd3, 8'd3, 0);
        wait_result(du, ds, lat);
        chk("t6_after_clr", {16'd0, du}, 32'd9);

        // Clear while a result is pending
        @(negedge clk);
        m_ready = 1'b0;
        push_win(8'd6, 8'd6, 8'd6, 8'd6, 0);
        wait_result(du, ds, lat);
        chk("t6_pending", {16'd0, du}, 32'd36);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t6_done_clr_valid", {31'd0, m_valid_u}, 32'd0);
        chk("t6_done_clr_ready", {31'd0, s_ready_u}, 32'd1);
        chk("t6_done_clr_data",  {16'd0, m_data_u},  32'd0);
        m_ready = 1'b1;
        push_win(8'd1, 8'd2, 8'd3, 8'd4, 0);
        wait_result(du, ds, lat);
        chk("t6_final", {16'd0, du}, 32'd7);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
